// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: Gray/binary
// conversion and the default address width.
package fifo_pkg;

  localparam int FIFO_ASIZE = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above its position.
module fifo_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // XOR-prefix from the MSB down
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and flag controller of the async FIFO. Runs entirely
// in the read clock domain against a write pointer that has already been
// synchronized into rclk, so every flag is pessimistic: it can only lag
// the true write position, never report data that is absent.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ASIZE     = FIFO_ASIZE,
  parameter int AEMPTY_TH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   r_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             r_aempty,
  output logic [ASIZE:0]   r_level,
  output logic             r_underflow
);

  localparam logic [ASIZE:0] AEMPTY_LIM = AEMPTY_TH[ASIZE:0];

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] level_q, level_d;
  logic           rempty_q, rempty_d;
  logic           aempty_q, aempty_d;
  logic           underflow_q, underflow_d;
  logic [ASIZE:0] wbin;
  logic           rd_en;

  fifo_gray2bin #(
    .WIDTH (ASIZE + 1)
  ) u_wptr_g2b (
    .gray (r_wptr),
    .bin  (wbin)
  );

  // Next pointer and flag values; level is computed against the pointer
  // after this cycle's read so a concurrent read and write cancel out.
  always_comb begin
    rd_en       = rinc & ~rempty_q;
    rbin_d      = rbin_q + {{ASIZE{1'b0}}, rd_en};
    rptr_d      = rbin_d ^ (rbin_d >> 1);
    level_d     = wbin - rbin_d;
    rempty_d    = (rptr_d == r_wptr);
    aempty_d    = (level_d <= AEMPTY_LIM);
    underflow_d = rinc & rempty_q;
  end

  // State registers; reset discards everything and ignores rinc
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rempty_q    <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      rempty_q    <= rempty_d;
      aempty_q    <= aempty_d;
      underflow_q <= underflow_d;
    end
  end

  assign rptr        = rptr_q;
  assign raddr       = rbin_q[ASIZE-1:0];
  assign rempty      = rempty_q;
  assign r_aempty    = aempty_q;
  assign r_level     = level_q;
  assign r_underflow = underflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty (ASIZE=4, AEMPTY_TH=2).
// A behavioural model pushes the expected post-edge outputs for every
// driven cycle; they are popped and compared one cycle later.
module tb_fifo_rptr_empty;

  localparam int ASIZE = 4;
  localparam int AEMPTY_TH = 2;
  localparam int PMOD = 1 << (ASIZE + 1);
  localparam int DEPTH = 1 << ASIZE;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rinc;
  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] raddr;
  logic             rempty;
  logic             r_aempty;
  logic [ASIZE:0]   r_level;
  logic             r_underflow;

  typedef struct {
    int rptr;
    int raddr;
    int empty;
    int aempty;
    int level;
    int uf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // model state: read count and write count, both modulo 2**(ASIZE+1)
  int m_rd = 0;
  int m_wr = 0;
  int m_empty = 1;

  fifo_rptr_empty #(
    .ASIZE     (ASIZE),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .rinc        (rinc),
    .r_wptr      (r_wptr),
    .rptr        (rptr),
    .raddr       (raddr),
    .rempty      (rempty),
    .r_aempty    (r_aempty),
    .r_level     (r_level),
    .r_underflow (r_underflow)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % PMOD;
  endfunction

  // drive one cycle, predict its outcome, then compare after the edge
  task automatic step(input logic rst_i, input logic rinc_i, input int wr_i);
    exp_t e;
    int lvl;
    rrst   = rst_i;
    rinc   = rinc_i;
    m_wr   = wr_i % PMOD;
    r_wptr = to_gray(m_wr);
    if (rst_i) begin
      m_rd    = 0;
      m_empty = 1;
      e.uf    = 0;
      e.level = 0;
      e.empty = 1;
      e.aempty = 1;
    end else begin
      e.uf = (rinc_i && m_empty) ? 1 : 0;
      if (rinc_i && !m_empty) m_rd = (m_rd + 1) % PMOD;
      lvl = (m_wr - m_rd + PMOD) % PMOD;
      e.level  = lvl;
      e.empty  = (lvl == 0) ? 1 : 0;
      e.aempty = (lvl <= AEMPTY_TH) ? 1 : 0;
      m_empty  = e.empty;
    end
    e.rptr  = to_gray(m_rd);
    e.raddr = m_rd % DEPTH;
    sb.push_back(e);
    @(posedge rclk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rptr",        int'(rptr),        e.rptr);
      chk("raddr",       int'(raddr),       e.raddr);
      chk("rempty",      int'(rempty),      e.empty);
      chk("r_aempty",    int'(r_aempty),    e.aempty);
      chk("r_level",     int'(r_level),     e.level);
      chk("r_underflow", int'(r_underflow), e.uf);
    end
  endtask

  initial begin
    rrst   = 1'b1;
    rinc   = 1'b0;
    r_wptr = '0;

    // reset for two cycles, with rinc asserted to show it is ignored
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    chk("reset_rptr_const",   int'(rptr), 0);
    chk("reset_rempty_const", int'(rempty), 1);

    // fill to 3 then drain with three reads
    step(1'b0, 1'b0, 3);
    chk("fill_level_const", int'(r_level), 3);
    step(1'b0, 1'b1, 3);
    chk("drain1_rptr_const", int'(rptr), 5'b00001);
    step(1'b0, 1'b1, 3);
    chk("drain2_rptr_const", int'(rptr), 5'b00011);
    step(1'b0, 1'b1, 3);
    chk("drain3_rptr_const", int'(rptr), 5'b00010);
    chk("drain3_raddr_const", int'(raddr), 3);

    // underflow: one read while empty, pulse lasts exactly one cycle
    step(1'b0, 1'b1, 3);
    chk("underflow_pulse_const", int'(r_underflow), 1);
    step(1'b0, 1'b0, 3);
    chk("underflow_clear_const", int'(r_underflow), 0);

    // wrap: full depth from rptr=0, drain, then a second full lap
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 16);
    chk("full_level_const", int'(r_level), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16);
    chk("wrap1_rptr_const", int'(rptr), 5'b11000);
    chk("wrap1_raddr_const", int'(raddr), 0);
    step(1'b0, 1'b0, 32);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32);
    chk("wrap2_rptr_const", int'(rptr), 0);
    chk("wrap2_rempty_const", int'(rempty), 1);

    // concurrent read and write keep the level constant
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 5);
    step(1'b0, 1'b1, 6);
    chk("concurrent_level_const", int'(r_level), 5);
    chk("concurrent_rptr_const", int'(rptr), 1);

    // mid-operation reset with a read pending
    step(1'b0, 1'b0, 8);
    chk("midop_level_const", int'(r_level), 7);
    step(1'b1, 1'b1, 8);
    chk("midop_rst_level_const", int'(r_level), 0);
    step(1'b1, 1'b0, 0);

    // random legal traffic
    for (int i = 0; i < 400; i++) begin
      int nw;
      nw = m_wr;
      if ((($urandom_range(0, 1)) == 1) && (((m_wr - m_rd + PMOD) % PMOD) < DEPTH))
        nw = m_wr + 1;
      step(1'b0, 1'($urandom_range(0, 1)), nw);
    end

    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
